// File: rtl/max_tree_seg.sv
// max_tree_seg
// Pipelined segmented max/argmax tree for the softmax approximation datapath.
// It reduces N_LANES signed lanes to 2^m independent segment maxima. The
// segment mode m is chosen per beat, and every mode leaves the pipe after
// LAT = log2(N_LANES) enabled cycles.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_en                  pipeline advance (0 freezes every register)
//   i_valid               beat valid
//   i_mode [MW]           segment mode m, segment size = N_LANES >> m
//                         (values above MAX_MODE are clamped)
//   i_lane_valid [N]      per-lane mask (0 = lane excluded)
//   i_data [N*DW]         lane k at [k*DW +: DW], signed
//   o_valid, o_mode       i_valid and clamped mode, delayed LAT
//   o_seg_valid [NSEG]    segment s has at least one valid lane
//   o_max [NSEG*DW]       segment s maximum
//   o_idx [NSEG*IW]       winning lane index, local to the segment
//   o_lane_valid_byp,
//   o_data_byp            input mask and data, delayed LAT
//
// MIN_SEG must be at least 2, so that the finest segmentation is taken
// from a registered tree level.
module max_tree_seg #(
  parameter int N_LANES = 64,
  parameter int DW      = 16,
  parameter int MIN_SEG = 16,
  localparam int LAT      = $clog2(N_LANES),
  localparam int NSEG     = N_LANES / MIN_SEG,
  localparam int MAX_MODE = $clog2(NSEG),
  localparam int MW       = ($clog2(MAX_MODE + 1) > 1) ? $clog2(MAX_MODE + 1) : 1,
  localparam int IW       = (LAT > 1) ? LAT : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [MW-1:0]           i_mode,
  input  logic [N_LANES-1:0]      i_lane_valid,
  input  logic [N_LANES*DW-1:0]   i_data,
  output logic                    o_valid,
  output logic [MW-1:0]           o_mode,
  output logic [NSEG-1:0]         o_seg_valid,
  output logic [NSEG*DW-1:0]      o_max,
  output logic [NSEG*IW-1:0]      o_idx,
  output logic [N_LANES-1:0]      o_lane_valid_byp,
  output logic [N_LANES*DW-1:0]   o_data_byp
);

  // First tree level whose nodes can be a segment result (coarsest mode).
  localparam int FIRST = LAT - MAX_MODE;
  localparam logic signed [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

  // Node rule: A (lower index) wins when valid and not beaten by a valid B.
  // Using >= sends ties to the lower index.
  function automatic logic pick_a(input logic va, input logic vb,
                                  input logic signed [DW-1:0] a,
                                  input logic signed [DW-1:0] b);
    return va & (~vb | (a >= b));
  endfunction

  logic [MW-1:0]         w_mode_clamp;
  logic [MW-1:0]         w_mode_at [LAT];
  logic [MW-1:0]         r_mode_pipe [LAT];
  logic [LAT-1:0]        r_valid_pipe;
  logic [N_LANES-1:0]    r_lv_pipe [LAT];
  logic [N_LANES*DW-1:0] r_data_pipe [LAT];

  // Result banks: bank k belongs to tree level FIRST+k. A bank either
  // captures its level, when the beat's mode selects that level, or carries
  // the previous bank forward. This lets every mode leave at the same depth.
  logic signed [DW-1:0]  r_bmax [MAX_MODE+1][NSEG];
  logic [IW-1:0]         r_bidx [MAX_MODE+1][NSEG];
  logic [NSEG-1:0]       r_bsv  [MAX_MODE+1];

  // Clamp the requested mode to the coarsest supported segmentation.
  always_comb begin
    if (i_mode > MW'(MAX_MODE)) begin
      w_mode_clamp = MW'(MAX_MODE);
    end else begin
      w_mode_clamp = i_mode;
    end
  end

  // Mode seen by each tree level: the input mode for level 0, pipelined after.
  always_comb begin
    w_mode_at[0] = w_mode_clamp;
    for (int k = 1; k < LAT; k++) begin
      w_mode_at[k] = r_mode_pipe[k-1];
    end
  end

  // Side-band pipeline: mode, valid, mask and data bypass, LAT deep.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_pipe <= {LAT{1'b0}};
      for (int k = 0; k < LAT; k++) begin
        r_mode_pipe[k] <= {MW{1'b0}};
        r_lv_pipe[k]   <= {N_LANES{1'b0}};
        r_data_pipe[k] <= {(N_LANES*DW){1'b0}};
      end
    end else if (i_en) begin
      r_mode_pipe[0]  <= w_mode_clamp;
      r_valid_pipe[0] <= i_valid;
      r_lv_pipe[0]    <= i_lane_valid;
      r_data_pipe[0]  <= i_data;
      for (int k = 1; k < LAT; k++) begin
        r_mode_pipe[k]  <= r_mode_pipe[k-1];
        r_valid_pipe[k] <= r_valid_pipe[k-1];
        r_lv_pipe[k]    <= r_lv_pipe[k-1];
        r_data_pipe[k]  <= r_data_pipe[k-1];
      end
    end
  end

  // g_lvl[j] holds tree level j (w_val/w_vld/w_idx) and computes the next
  // level (w_nval/w_nvld/w_nidx). Level j carries a j-bit local index.
  for (genvar j = 0; j < LAT; j++) begin : g_lvl
    localparam int NN = N_LANES >> j;
    localparam int HN = NN / 2;
    localparam int JW = (j == 0) ? 1 : j;
    localparam int OW = j + 1;

    logic signed [DW-1:0] w_val  [NN];
    logic                 w_vld  [NN];
    logic [JW-1:0]        w_idx  [NN];
    logic signed [DW-1:0] w_nval [HN];
    logic                 w_nvld [HN];
    logic [OW-1:0]        w_nidx [HN];

    if (j == 0) begin : g_in
      // Input masking: an excluded lane enters as NEG_MIN with valid 0.
      always_comb begin
        for (int n = 0; n < NN; n++) begin
          if (i_lane_valid[n]) begin
            w_val[n] = i_data[n*DW +: DW];
            w_vld[n] = 1'b1;
          end else begin
            w_val[n] = NEG_MIN;
            w_vld[n] = 1'b0;
          end
          w_idx[n] = 1'b0;
        end
      end
    end else begin : g_reg
      logic signed [DW-1:0] r_val [NN];
      logic                 r_vld [NN];
      logic [JW-1:0]        r_idx [NN];

      // Level register: captures the nodes computed from the level below.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int n = 0; n < NN; n++) begin
            r_val[n] <= {DW{1'b0}};
            r_vld[n] <= 1'b0;
            r_idx[n] <= {JW{1'b0}};
          end
        end else if (i_en) begin
          for (int n = 0; n < NN; n++) begin
            r_val[n] <= g_lvl[j-1].w_nval[n];
            r_vld[n] <= g_lvl[j-1].w_nvld[n];
            r_idx[n] <= g_lvl[j-1].w_nidx[n];
          end
        end
      end

      // Expose the registered level to the node logic.
      always_comb begin
        for (int n = 0; n < NN; n++) begin
          w_val[n] = r_val[n];
          w_vld[n] = r_vld[n];
          w_idx[n] = r_idx[n];
        end
      end
    end

    // 2:1 nodes. The new index MSB is set when the upper child (B) wins.
    always_comb begin
      for (int n = 0; n < HN; n++) begin
        if (!w_vld[2*n] && !w_vld[2*n+1]) begin
          w_nval[n] = NEG_MIN;
          w_nvld[n] = 1'b0;
          w_nidx[n] = {OW{1'b0}};
        end else if (pick_a(w_vld[2*n], w_vld[2*n+1], w_val[2*n], w_val[2*n+1])) begin
          w_nval[n] = w_val[2*n];
          w_nvld[n] = 1'b1;
          w_nidx[n] = OW'(w_idx[2*n]);
        end else begin
          w_nval[n] = w_val[2*n+1];
          w_nvld[n] = 1'b1;
          w_nidx[n] = OW'(w_idx[2*n+1]) | (OW'(1'b1) << j);
        end
      end
    end

    if (j + 1 >= FIRST) begin : g_cap
      localparam int K = j + 1 - FIRST;
      logic signed [DW-1:0] w_pmax [NSEG];
      logic [IW-1:0]        w_pidx [NSEG];
      logic [NSEG-1:0]      w_psv;

      if (K == 0) begin : g_head
        // Nothing upstream: the bank is empty until a mode captures.
        always_comb begin
          for (int s = 0; s < NSEG; s++) begin
            w_pmax[s] = {DW{1'b0}};
            w_pidx[s] = {IW{1'b0}};
          end
          w_psv = {NSEG{1'b0}};
        end
      end else begin : g_tail
        // Previous bank, carried forward as alignment delay.
        always_comb begin
          for (int s = 0; s < NSEG; s++) begin
            w_pmax[s] = r_bmax[K-1][s];
            w_pidx[s] = r_bidx[K-1][s];
          end
          w_psv = r_bsv[K-1];
        end
      end

      // Capture level j+1 when it is the mode's segment level (2^m nodes).
      // Unused slots are zeroed.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int s = 0; s < NSEG; s++) begin
            r_bmax[K][s] <= {DW{1'b0}};
            r_bidx[K][s] <= {IW{1'b0}};
          end
          r_bsv[K] <= {NSEG{1'b0}};
        end else if (i_en) begin
          if (w_mode_at[j] == MW'(LAT - 1 - j)) begin
            for (int s = 0; s < HN; s++) begin
              r_bmax[K][s] <= w_nval[s];
              r_bidx[K][s] <= IW'(w_nidx[s]);
              r_bsv[K][s]  <= w_nvld[s];
            end
            for (int s = HN; s < NSEG; s++) begin
              r_bmax[K][s] <= {DW{1'b0}};
              r_bidx[K][s] <= {IW{1'b0}};
              r_bsv[K][s]  <= 1'b0;
            end
          end else begin
            for (int s = 0; s < NSEG; s++) begin
              r_bmax[K][s] <= w_pmax[s];
              r_bidx[K][s] <= w_pidx[s];
            end
            r_bsv[K] <= w_psv;
          end
        end
      end
    end
  end

  // Flatten the last bank onto the output ports.
  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      o_max[s*DW +: DW] = r_bmax[MAX_MODE][s];
      o_idx[s*IW +: IW] = r_bidx[MAX_MODE][s];
    end
  end

  assign o_seg_valid      = r_bsv[MAX_MODE];
  assign o_valid          = r_valid_pipe[LAT-1];
  assign o_mode           = r_mode_pipe[LAT-1];
  assign o_lane_valid_byp = r_lv_pipe[LAT-1];
  assign o_data_byp       = r_data_pipe[LAT-1];

endmodule

// File: tb/tb_max_tree_seg.sv
// Directed testbench for max_tree_seg with the default parameters
// (64 lanes, 16-bit data, minimum segment 16, latency 6).
module tb_max_tree_seg;
  localparam int N    = 64;
  localparam int DW   = 16;
  localparam int NSEG = 4;
  localparam int IW   = 6;
  localparam int LAT  = 6;

  logic              i_clk;
  logic              i_rst;
  logic              i_en;
  logic              i_valid;
  logic [1:0]        i_mode;
  logic [N-1:0]      i_lane_valid;
  logic [N*DW-1:0]   i_data;
  logic              o_valid;
  logic [1:0]        o_mode;
  logic [NSEG-1:0]   o_seg_valid;
  logic [NSEG*DW-1:0] o_max;
  logic [NSEG*IW-1:0] o_idx;
  logic [N-1:0]      o_lane_valid_byp;
  logic [N*DW-1:0]   o_data_byp;

  max_tree_seg dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
    .i_mode(i_mode), .i_lane_valid(i_lane_valid), .i_data(i_data),
    .o_valid(o_valid), .o_mode(o_mode), .o_seg_valid(o_seg_valid),
    .o_max(o_max), .o_idx(o_idx), .o_lane_valid_byp(o_lane_valid_byp),
    .o_data_byp(o_data_byp)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Stimulus under construction and the expected table for each beat id.
  logic [N*DW-1:0]     cur_data;
  logic [N-1:0]        cur_lv;
  logic [N*DW-1:0]     tbl_data [16];
  logic [N-1:0]        tbl_lv   [16];
  logic [1:0]          tbl_mode [16];
  logic [3:0]          tbl_sv   [16];
  logic [NSEG*DW-1:0]  tbl_mx   [16];
  logic [NSEG*IW-1:0]  tbl_ix   [16];
  // Delay line of beat ids (-1 = no valid beat), advanced on enabled edges.
  int                  model [LAT];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input int id, input logic [1:0] mode, input logic [3:0] sv,
                         input int m0, input int m1, input int m2, input int m3,
                         input int x0, input int x1, input int x2, input int x3);
    tbl_mode[id] = mode;
    tbl_sv[id]   = sv;
    tbl_mx[id]   = {m3[15:0], m2[15:0], m1[15:0], m0[15:0]};
    tbl_ix[id]   = {x3[5:0], x2[5:0], x1[5:0], x0[5:0]};
  endtask

  // All lanes = fill, lane p = v, every lane valid.
  task automatic beat(input int fill, input int p, input int v);
    for (int k = 0; k < N; k++) cur_data[k*DW +: DW] = 16'(fill);
    cur_data[p*DW +: DW] = 16'(v);
    cur_lv = {N{1'b1}};
  endtask

  task automatic tick(input logic en, input logic rst, input logic vld,
                      input logic [1:0] mode, input int id);
    int e;
    i_en = en; i_rst = rst; i_valid = vld; i_mode = mode;
    i_data = cur_data; i_lane_valid = cur_lv;
    if (en && !rst && vld) begin
      tbl_data[id] = cur_data;
      tbl_lv[id]   = cur_lv;
    end
    @(posedge i_clk);
    #1;
    if (rst) begin
      for (int k = 0; k < LAT; k++) model[k] = -1;
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_mode", o_mode, 2'd0);
      chk("rst_seg_valid", o_seg_valid, 4'd0);
      chk("rst_max", o_max, 64'd0);
      chk("rst_idx", o_idx, 24'd0);
      chk("rst_lv_byp", o_lane_valid_byp, 64'd0);
      for (int c = 0; c < 4; c++) chk("rst_data_byp", o_data_byp[c*256 +: 256], 256'd0);
    end else begin
      if (en) begin
        for (int k = LAT - 1; k > 0; k--) model[k] = model[k-1];
        model[0] = vld ? id : -1;
      end
      e = model[LAT-1];
      chk("valid", o_valid, (e >= 0));
      if (e >= 0) begin
        chk($sformatf("mode[%0d]", e), o_mode, tbl_mode[e]);
        chk($sformatf("seg_valid[%0d]", e), o_seg_valid, tbl_sv[e]);
        chk($sformatf("max[%0d]", e), o_max, tbl_mx[e]);
        chk($sformatf("idx[%0d]", e), o_idx, tbl_ix[e]);
        chk($sformatf("lv_byp[%0d]", e), o_lane_valid_byp, tbl_lv[e]);
        for (int c = 0; c < 4; c++)
          chk($sformatf("data_byp[%0d].%0d", e, c), o_data_byp[c*256 +: 256], tbl_data[e][c*256 +: 256]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 2'd0, 0);
  endtask

  initial begin
    cur_data = '0;
    cur_lv   = '0;
    for (int k = 0; k < LAT; k++) model[k] = -1;

    // Reset
    tick(1'b1, 1'b1, 1'b0, 2'd0, 0);
    tick(1'b1, 1'b1, 1'b0, 2'd0, 0);
    idle(2);

    // Mode 0, lane k = k-32: max 31 at lane 63
    for (int k = 0; k < N; k++) cur_data[k*DW +: DW] = 16'(k - 32);
    cur_lv = {N{1'b1}};
    set_exp(0, 2'd0, 4'b0001, 31, 0, 0, 0, 63, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd0, 0);
    idle(7);

    // Mode 2, four segments
    beat(-500, 5, 100);
    cur_data[20*DW +: DW] = 16'(-7);
    cur_data[40*DW +: DW] = 16'(300);
    cur_data[63*DW +: DW] = 16'(-1);
    set_exp(1, 2'd2, 4'b1111, 100, -7, 300, -1, 5, 4, 8, 15);
    tick(1'b1, 1'b0, 1'b1, 2'd2, 1);
    idle(7);

    // Mode 1, masked tie at lane 3, upper half fully masked
    beat(0, 3, 42);
    cur_data[10*DW +: DW] = 16'(42);
    cur_lv[3] = 1'b0;
    cur_lv[63:32] = 32'd0;
    set_exp(2, 2'd1, 4'b0001, 42, -32768, 0, 0, 10, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd1, 2);
    idle(7);

    // Back-to-back beats, modes 0,1,2,2,0, with enable gaps
    beat(-100, 7, 1000);
    set_exp(3, 2'd0, 4'b0001, 1000, 0, 0, 0, 7, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd0, 3);
    beat(-100, 40, 2000);
    set_exp(4, 2'd1, 4'b0011, -100, 2000, 0, 0, 0, 8, 0, 0);
    tick(1'b0, 1'b0, 1'b1, 2'd1, 4);
    tick(1'b1, 1'b0, 1'b1, 2'd1, 4);
    beat(-100, 17, 3000);
    set_exp(5, 2'd2, 4'b1111, -100, 3000, -100, -100, 0, 1, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd2, 5);
    beat(-100, 63, -50);
    set_exp(6, 2'd2, 4'b1111, -100, -100, -100, -50, 0, 0, 0, 15);
    tick(1'b0, 1'b0, 1'b1, 2'd2, 6);
    tick(1'b1, 1'b0, 1'b1, 2'd2, 6);
    beat(-100, 0, -99);
    set_exp(7, 2'd0, 4'b0001, -99, 0, 0, 0, 0, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd0, 7);
    for (int i = 0; i < 12; i++) tick((i % 3) != 0, 1'b0, 1'b0, 2'd0, 0);

    // Out-of-range mode 3 acts as mode 2; all lanes tie at -32768
    beat(-32768, 0, -32768);
    set_exp(8, 2'd2, 4'b1111, -32768, -32768, -32768, -32768, 0, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd3, 8);
    idle(7);

    // Reset (with enable low) while three beats are in flight
    beat(5, 1, 9);
    set_exp(9, 2'd0, 4'b0001, 9, 0, 0, 0, 1, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd0, 9);
    set_exp(10, 2'd0, 4'b0001, 9, 0, 0, 0, 1, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd0, 10);
    set_exp(11, 2'd0, 4'b0001, 9, 0, 0, 0, 1, 0, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd0, 11);
    tick(1'b0, 1'b1, 1'b0, 2'd0, 0);
    idle(3);
    beat(-1, 50, 77);
    set_exp(12, 2'd1, 4'b0011, -1, 77, 0, 0, 0, 18, 0, 0);
    tick(1'b1, 1'b0, 1'b1, 2'd1, 12);
    idle(7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/max_tree_seg.md
Name: max_tree_seg

Overview:
- Parametrised, fully pipelined segmented max/argmax tree for the softmax approximation datapath.
- Reduces N_LANES signed lanes to one, two, four or more independent segment maxima, selected per beat by a segment mode.
- Reports per-segment max value, winning lane index and segment-valid flag, plus an aligned bypass of the input vector for the downstream subtract/exp stage.
- All modes share one fixed latency; masked lanes never win.

Parameters:
- N_LANES, 64, input lane count; power of 2, at least 2.
- DW, 16, lane width; signed two's complement.
- MIN_SEG, 16, smallest segment size; power of 2, at most N_LANES.
- Derived: LAT = log2(N_LANES); NSEG = N_LANES/MIN_SEG; MAX_MODE = log2(NSEG); MW = max(1, clog2(MAX_MODE+1)); IW = max(1, log2(N_LANES)).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_en  in  1  pipeline advance; 0 freezes every register
- i_valid  in  1  beat valid
- i_mode  in  MW  segment mode m; segment size = N_LANES >> m
- i_lane_valid  in  N_LANES  per-lane mask; 0 means exclude the lane
- i_data  in  N_LANES*DW  lane k at bits [k*DW +: DW]
- o_valid  out  1  i_valid delayed LAT
- o_mode  out  MW  clamped mode delayed LAT
- o_seg_valid  out  NSEG  segment s has at least one valid lane
- o_max  out  NSEG*DW  segment s max at [s*DW +: DW]
- o_idx  out  NSEG*IW  winning lane index within the segment (local, 0-based)
- o_lane_valid_byp  out  N_LANES  i_lane_valid delayed LAT
- o_data_byp  out  N_LANES*DW  i_data delayed LAT

Behaviour:
- Reset: i_rst is synchronous and active-high, clock i_clk. Reset has priority over i_en and clears every register, so every output reads 0 after reset.
- Enable: when i_en=0, every register holds. Latency is counted in enabled cycles only.
- Input masking: at the input, a lane with i_lane_valid=0 is replaced by NEG_MIN = -2^(DW-1) with a lane-valid bit of 0.
- Tree structure: LAT registered stages, each made of 2:1 nodes. A node selects A (the lower index) when validA & (!validB | A >= B); otherwise it selects B. Ties therefore go to the lower index. Comparison is signed.
- Node valid = validA | validB.
- Index: the node carries a local index whose width grows by 1 bit per stage. The new bit is 1 when B is selected.
- All-invalid pair: output is NEG_MIN, valid 0, index 0.
- Mode handling: i_mode is clamped to MAX_MODE and pipelined with the data.
- Mode output mapping: in mode m, segment size is S = N_LANES >> m, and the result is taken from tree stage log2(S). That result is delayed through (LAT - log2(S)) alignment registers so that every mode emerges at exactly LAT.
  - Output slots 0 .. 2^m - 1 carry segments 0 .. 2^m - 1.
  - Slots at or above 2^m are driven to max=0, idx=0, seg_valid=0.
- Mode changes: the mode may change on any beat. There are no bubbles and beats do not cross-contaminate, because each beat carries its own pipelined mode.
- Output qualification: outputs are produced every enabled cycle regardless of i_valid. o_valid only qualifies them; downstream ignores beats with o_valid=0.
- Index width: o_idx is zero-extended to IW bits for slots whose segment needs fewer bits.
- Bypass: the bypass, o_mode and o_valid path is exactly LAT enabled-cycles deep, bit-aligned with o_max.
- Reset mid-stream: all in-flight beats are discarded. The first beat accepted after reset emerges after LAT enabled cycles.
- Throughput: one beat per enabled cycle. There is no back-pressure beyond i_en.

Test Plan:
- Defaults, mode 0: lane k = k-32, all lanes valid, i_valid=1 for 1 cycle -> exactly 6 enabled cycles later o_valid=1, o_max[0]=31, o_idx[0]=63, o_seg_valid=4'b0001, other slots 0, o_data_byp equals the input.
- Mode 2, with lane 5=100, lane 20=-7, lane 40=300, lane 63=-1 and all other lanes -500 -> slots (100,5), (-7,4), (300,8), (-1,15); o_seg_valid=4'b1111; latency 6.
- Mask and tie: mode 1; lanes 3 and 10 = 42 with lane 3 masked; lanes 32..63 all masked; all other lanes = 0 -> slot0 = (42, idx 10), slot1 = (-32768, idx 0, seg_valid 0).
- Back-to-back beats with modes 0,1,2,2,0 and distinct data; i_en pattern 1,0,1,1,0,1... -> results emerge in order with the matching o_mode, each exactly 6 enabled cycles after entry, and outputs hold during i_en=0.
- Out-of-range mode 3 -> behaves as mode 2, o_mode=2. Ties in all 64 lanes at -32768 -> idx 0 in every slot.
- Assert i_rst with 3 beats in flight -> all outputs 0 on the next cycle. No stale o_valid afterwards. A new beat emerges at cycle 6.
